// File: rtl/tl_inflight_tracker.sv
// tl_inflight_tracker
//   Protocol-state stage for one TileLink-UL A/D channel pair. Tracks which
//   source IDs have an outstanding request, counts burst beats on both
//   channels, checks each D response against the request it answers, and
//   runs a no-progress watchdog. Violations come out as registered one-cycle
//   pulses plus a sticky first-error code.
//
// Handshake: a beat transfers on a channel exactly in a cycle where both
//   valid and ready are high at the rising edge (a_fire / d_fire). Nothing
//   else on a channel has any effect, and this block never drives ready.
//
// Ports
//   clock, reset         sole clock; synchronous active-high reset
//   a_valid, a_ready     A handshake
//   a_opcode/size/source A request fields
//   d_valid, d_ready     D handshake
//   d_opcode/size/source D response fields
//   err_dup_source       pulse: A first beat on an already pending source
//   err_no_request       pulse: D first beat on a source with nothing pending
//   err_mismatch         pulse: D size/opcode differs from the stored expectation
//   err_timeout          pulse: watchdog expired
//   err_code             sticky first error (0 none,1 dup,2 noreq,3 mismatch,4 timeout)
//   inflight_count       number of pending sources
module tl_inflight_tracker #(
    parameter int SOURCE_BITS     = 3,
    parameter int BEAT_BYTES_LOG2 = 3,
    parameter int TIMEOUT         = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [2:0]             a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [2:0]             d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    output logic                   err_dup_source,
    output logic                   err_no_request,
    output logic                   err_mismatch,
    output logic                   err_timeout,
    output logic [2:0]             err_code,
    output logic [SOURCE_BITS:0]   inflight_count
);

    localparam int NSRC = 1 << SOURCE_BITS;
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ARM = WD_W'(TIMEOUT - 2);

    logic [NSRC-1:0] pending_q;
    logic [2:0]      size_q [NSRC];
    logic [2:0]      op_q   [NSRC];
    logic [7:0]      a_beat_cnt;
    logic [7:0]      d_beat_cnt;
    logic            d_ok_q;      // current multi-beat D burst answers a pending request
    logic [WD_W-1:0] wd_cnt;

    logic            a_take, a_multi, a_first, a_last;
    logic            d_fire, d_multi, d_first, d_last, d_tracked;
    logic [7:0]      a_beats_m1, d_beats_m1;
    logic [NSRC-1:0] retire_mask, pending_ret, pending_d;
    logic            dup, record, noreq, mismatch, wd_clear, timeout_hit;
    logic [2:0]      exp_op;

    function automatic logic [SOURCE_BITS:0] popcount(input logic [NSRC-1:0] v);
        logic [SOURCE_BITS:0] c;
        c = '0;
        for (int i = 0; i < NSRC; i++) c = c + {{SOURCE_BITS{1'b0}}, v[i]};
        return c;
    endfunction

    always_comb begin
        // Opcodes 6/7 are not TileLink-UL requests; they change nothing.
        a_take     = a_valid && a_ready && (a_opcode <= 3'd5);
        a_multi    = (a_opcode <= 3'd1) && (int'(a_size) > BEAT_BYTES_LOG2);
        a_beats_m1 = a_multi ? ((8'd1 << (a_size - 3'(BEAT_BYTES_LOG2))) - 8'd1) : 8'd0;
        a_first    = a_take && (a_beat_cnt == 8'd0);
        a_last     = a_take && (a_beat_cnt == a_beats_m1);

        d_fire     = d_valid && d_ready;
        d_multi    = (d_opcode == 3'd1) && (int'(d_size) > BEAT_BYTES_LOG2);
        d_beats_m1 = d_multi ? ((8'd1 << (d_size - 3'(BEAT_BYTES_LOG2))) - 8'd1) : 8'd0;
        d_first    = d_fire && (d_beat_cnt == 8'd0);
        d_last     = d_fire && (d_beat_cnt == d_beats_m1);
        d_tracked  = d_first ? pending_q[d_source] : d_ok_q;

        // Retire before record so a same-cycle reuse of a source is legal.
        retire_mask = (d_last && d_tracked) ? (NSRC'(1) << d_source) : '0;
        pending_ret = pending_q & ~retire_mask;
        dup         = a_first && pending_ret[a_source];
        record      = a_first && !dup;
        pending_d   = pending_ret | (record ? (NSRC'(1) << a_source) : '0);

        noreq    = d_first && !pending_q[d_source];
        mismatch = d_first && pending_q[d_source] &&
                   ((d_size != size_q[d_source]) || (d_opcode != op_q[d_source]));

        case (a_opcode)
            3'd0, 3'd1:       exp_op = 3'd0;
            3'd2, 3'd3, 3'd4: exp_op = 3'd1;
            default:          exp_op = 3'd2;
        endcase

        wd_clear    = d_fire || (inflight_count == '0);
        // Fires on the edge where the counter steps onto TIMEOUT-1; saturation
        // keeps it from firing again until a clear.
        timeout_hit = !wd_clear && (wd_cnt == WD_ARM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q      <= '0;
            for (int i = 0; i < NSRC; i++) begin
                size_q[i] <= '0;
                op_q[i]   <= '0;
            end
            a_beat_cnt     <= '0;
            d_beat_cnt     <= '0;
            d_ok_q         <= 1'b0;
            wd_cnt         <= '0;
            err_dup_source <= 1'b0;
            err_no_request <= 1'b0;
            err_mismatch   <= 1'b0;
            err_timeout    <= 1'b0;
            err_code       <= 3'd0;
            inflight_count <= '0;
        end else begin
            pending_q <= pending_d;
            if (record) begin
                size_q[a_source] <= a_size;
                op_q[a_source]   <= exp_op;
            end
            if (a_take) a_beat_cnt <= a_last ? 8'd0 : a_beat_cnt + 8'd1;
            if (d_fire) d_beat_cnt <= d_last ? 8'd0 : d_beat_cnt + 8'd1;
            if (d_first) d_ok_q <= pending_q[d_source];

            if (wd_clear)             wd_cnt <= '0;
            else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;

            err_dup_source <= dup;
            err_no_request <= noreq;
            err_mismatch   <= mismatch;
            err_timeout    <= timeout_hit;
            if (err_code == 3'd0) begin
                if (dup)              err_code <= 3'd1;
                else if (noreq)       err_code <= 3'd2;
                else if (mismatch)    err_code <= 3'd3;
                else if (timeout_hit) err_code <= 3'd4;
            end
            inflight_count <= popcount(pending_d);
        end
    end

endmodule
